instr_fetch_unit: RTL and testbench
===================================

# instr_fetch_unit

Instruction fetch stage directly upstream of the control unit. Holds the program counter, issues instruction-memory reads with a request/hit handshake, and latches the fetched word as the `instr` driven into the decoder. Computes the next PC from branch, jump and jump-register selects returned by decode/datapath, and stops fetching on halt.

## Interface
- `PC_INIT`, 32'h0000_0000, PC value loaded at reset
- `CLK`  in  1  system clock, rising edge
- `nRST`  in  1  asynchronous active-low reset
- `ihit`  in  1  instruction memory read complete; `imemload` valid this cycle
- `imemload`  in  32  instruction word from memory
- `imemREN`  out  1  instruction read request
- `imemaddr`  out  32  read address (current PC)
- `instr`  out  32  latched instruction to the decoder
- `instr_valid`  out  1  `instr` is current and awaiting retirement
- `npc`  out  32  PC+4 of the held instruction (for JAL link)
- `advance`  in  1  datapath has finished the held instruction
- `branch_taken`  in  1  take branch (decoder `pc_src`)
- `jump`  in  1  J/JAL target select
- `jr`  in  1  jump-register select
- `jr_addr`  in  32  register value for JR
- `halt`  in  1  held instruction is HALT
- `halted`  out  1  fetch stopped, sticky until reset
- `fetch_cnt`  out  32  fetched-instruction count (see Configuration)
- `wait_cnt`  out  32  cycles spent waiting for `ihit` (see Configuration)

## Operation
- States: IDLE, FETCH, HOLD, HALT. Reset state IDLE.
- IDLE: `imemREN`=0; unconditionally to FETCH next cycle.
- FETCH: `imemREN`=1, `imemaddr`=PC. On `ihit`: `instr`<=`imemload`, `instr_valid`<=1, go HOLD. Without `ihit`: stay, PC and `instr` unchanged. `advance` ignored.
- HOLD: `imemREN`=0. `ihit` ignored. On `advance`:
  - `halt`=1: go HALT, PC unchanged, `instr_valid`<=0.
  - else PC<=next PC, `instr_valid`<=0, go FETCH.
- HALT: `imemREN`=0, `halted`=1; all inputs ignored; exit only via `nRST`.
- Next PC priority: `jr` > `jump` > `branch_taken` > PC+4.
  - JR: `{jr_addr[31:2],2'b00}` (low bits forced to zero).
  - Jump: `{npc[31:28], instr[25:0], 2'b00}`.
  - Branch: `npc + {{14{instr[15]}}, instr[15:0], 2'b00}`.
- All PC arithmetic is 32-bit modulo; 32'hFFFF_FFFC + 4 wraps to 0.
- `npc` = PC+4, combinational from PC.
- Reset mid-operation: any state to IDLE immediately; pending read abandoned.

## Timing
- Reset values: PC=`PC_INIT`, `instr`=0, `instr_valid`=0, `imemREN`=0, `halted`=0, both counters 0.
- First request: `imemREN` rises in the 2nd cycle after `nRST` deasserts (IDLE, then FETCH).
- `ihit` in cycle k: `instr`/`instr_valid` updated at the k+1 edge.
- `advance` in cycle m (HOLD): new PC and `imemREN`=1 in cycle m+1.
- Best-case throughput: 2 cycles per instruction (`ihit` same cycle as FETCH entry, `advance` same cycle as HOLD entry).
- `imemaddr` is stable for the whole FETCH residency.

## Configuration
- `FETCH_PERF_EN` defined:
  - `fetch_cnt` increments on each accepted `ihit` in FETCH.
  - `wait_cnt` increments on each FETCH cycle without `ihit`.
  - Both saturate at 32'hFFFF_FFFF.
- Not defined: both ports tied to 0; no counter registers.

## Test plan
- Reset with `PC_INIT`=0, `ihit` tied 1, `advance` tied 1, all selects 0 -> `imemaddr` sequence 0,4,8,… one new address every 2 cycles; `instr_valid` toggles.
- Hold `ihit`=0 for 3 FETCH cycles at PC=0x40, then 1 -> `imemaddr` stays 0x40; `wait_cnt`=3 with `FETCH_PERF_EN`; `instr` = `imemload` on the next cycle.
- PC=0x100, `instr`=BEQ with imm16=0xFFFF, `branch_taken`=1 -> next `imemaddr`=0x100.
- PC=0x2000_0000, J target 26'h0000010 with `jr`=1 and `jr_addr`=0x0000_0333 asserted together -> next address 0x0000_0330 (JR wins, low bits cleared).
- `halt`=1 with `advance` -> `halted`=1, `imemREN` stays 0 under further `ihit`/`advance`; `nRST` pulse mid-HOLD -> PC=`PC_INIT`, `instr_valid`=0.
- PC=0xFFFF_FFFC, sequential advance -> next `imemaddr`=0x0000_0000.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: PC, imem request/hit handshake, held instruction and next-PC select.
// Optional performance counters enabled with `define FETCH_PERF_EN.
module instr_fetch_unit #(
  parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        ihit,
  input  logic [31:0] imemload,
  output logic        imemREN,
  output logic [31:0] imemaddr,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [31:0] npc,
  input  logic        advance,
  input  logic        branch_taken,
  input  logic        jump,
  input  logic        jr,
  input  logic [31:0] jr_addr,
  input  logic        halt,
  output logic        halted,
  output logic [31:0] fetch_cnt,
  output logic [31:0] wait_cnt
);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD, HALT} state_t;

  state_t      r_state, w_next;
  logic [31:0] r_pc, r_instr, w_npc, w_br_off, w_next_pc;
  logic        r_instr_valid;
  logic        w_accept, w_retire;

  assign w_npc    = r_pc + 32'd4;
  assign w_br_off = {{14{r_instr[15]}}, r_instr[15:0], 2'b00};

  always_comb begin
    w_next_pc = w_npc;
    if (jr)                w_next_pc = jr_addr & 32'hFFFF_FFFC;
    else if (jump)         w_next_pc = {w_npc[31:28], r_instr[25:0], 2'b00};
    else if (branch_taken) w_next_pc = w_npc + w_br_off;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    imemREN  = 1'b0;
    halted   = 1'b0;
    w_accept = 1'b0;
    w_retire = 1'b0;
    case (r_state)
      IDLE:  w_next = FETCH;
      FETCH: begin
        imemREN  = 1'b1;
        w_accept = ihit;
        if (ihit) w_next = HOLD;
      end
      HOLD: begin
        w_retire = advance;
        if (advance) w_next = halt ? HALT : FETCH;
      end
      HALT:    halted = 1'b1;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_pc          <= PC_INIT;
      r_instr       <= '0;
      r_instr_valid <= 1'b0;
    end else begin
      if (w_accept) begin
        r_instr       <= imemload;
        r_instr_valid <= 1'b1;
      end
      if (w_retire) begin
        r_instr_valid <= 1'b0;
        if (!halt) r_pc <= w_next_pc;
      end
    end
  end

  assign imemaddr    = r_pc;
  assign npc         = w_npc;
  assign instr       = r_instr;
  assign instr_valid = r_instr_valid;

`ifdef FETCH_PERF_EN
  logic [31:0] r_fetch_cnt, r_wait_cnt;

  // Both counters stick at all-ones rather than wrapping.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_fetch_cnt <= '0;
      r_wait_cnt  <= '0;
    end else if (r_state == FETCH) begin
      if (ihit && r_fetch_cnt != 32'hFFFF_FFFF)  r_fetch_cnt <= r_fetch_cnt + 32'd1;
      if (!ihit && r_wait_cnt != 32'hFFFF_FFFF)  r_wait_cnt  <= r_wait_cnt + 32'd1;
    end
  end

  assign fetch_cnt = r_fetch_cnt;
  assign wait_cnt  = r_wait_cnt;
`else
  assign fetch_cnt = '0;
  assign wait_cnt  = '0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomized bench for instr_fetch_unit against a transaction-level model of fetch/hold/halt.
module tb_instr_fetch_unit;

  logic        CLK = 1'b0, nRST = 1'b0;
  logic        ihit = 1'b0, advance = 1'b0, branch_taken = 1'b0, jump = 1'b0, jr = 1'b0, halt = 1'b0;
  logic [31:0] imemload = '0, jr_addr = '0;
  logic        imemREN, instr_valid, halted;
  logic [31:0] imemaddr, instr, npc, fetch_cnt, wait_cnt;

  instr_fetch_unit #(.PC_INIT(32'h0)) dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .imemload(imemload), .imemREN(imemREN),
    .imemaddr(imemaddr), .instr(instr), .instr_valid(instr_valid), .npc(npc),
    .advance(advance), .branch_taken(branch_taken), .jump(jump), .jr(jr),
    .jr_addr(jr_addr), .halt(halt), .halted(halted), .fetch_cnt(fetch_cnt), .wait_cnt(wait_cnt)
  );

  always #5 CLK = ~CLK;

  int n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Model: a word is either being requested, held for the datapath, or fetch has stopped.
  logic [31:0] m_pc, m_instr, m_fcnt, m_wcnt;
  logic        m_boot, m_valid, m_halted;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  function automatic logic [31:0] model_next_pc();
    logic [31:0] seq;
    int          off;
    seq = m_pc + 32'd4;
    off = int'($signed(m_instr[15:0])) * 4;
    if (jr)           return jr_addr & 32'hFFFF_FFFC;
    if (jump)         return (seq & 32'hF000_0000) | ((m_instr & 32'h03FF_FFFF) << 2);
    if (branch_taken) return seq + 32'(off);
    return seq;
  endfunction

  task automatic model_reset();
    m_pc = 32'h0; m_instr = '0; m_valid = 0; m_halted = 0; m_boot = 1;
    m_fcnt = '0; m_wcnt = '0;
  endtask

  task automatic check_outputs();
    chk("imemREN", 32'(imemREN), 32'(!m_boot && !m_halted && !m_valid));
    chk("imemaddr", imemaddr, m_pc);
    chk("npc", npc, m_pc + 32'd4);
    chk("instr", instr, m_instr);
    chk("instr_valid", 32'(instr_valid), 32'(m_valid));
    chk("halted", 32'(halted), 32'(m_halted));
`ifdef FETCH_PERF_EN
    chk("fetch_cnt", fetch_cnt, m_fcnt);
    chk("wait_cnt", wait_cnt, m_wcnt);
`else
    chk("fetch_cnt", fetch_cnt, 32'h0);
    chk("wait_cnt", wait_cnt, 32'h0);
`endif
  endtask

  // Called at a negedge: check, drive, clock, advance model, return at next negedge.
  task automatic step(input logic i_hit, input logic [31:0] i_load, input logic i_adv,
                      input logic i_br, input logic i_j, input logic i_jr,
                      input logic [31:0] i_jra, input logic i_halt);
    logic [31:0] nxt;
    check_outputs();
    ihit = i_hit; imemload = i_load; advance = i_adv; branch_taken = i_br;
    jump = i_j; jr = i_jr; jr_addr = i_jra; halt = i_halt;
    nxt = model_next_pc();
    @(posedge CLK);
    if (m_halted) begin
    end else if (m_boot) begin
      m_boot = 0;
    end else if (!m_valid) begin
      if (i_hit) begin m_instr = i_load; m_valid = 1; m_fcnt = sat_inc(m_fcnt); end
      else       m_wcnt = sat_inc(m_wcnt);
    end else if (i_adv) begin
      m_valid = 0;
      if (i_halt) m_halted = 1;
      else        m_pc = nxt;
    end
    @(negedge CLK);
  endtask

  task automatic do_reset();
    nRST = 1'b0;
    #1;
    model_reset();
    check_outputs();
    #1;
    nRST = 1'b1;
  endtask

  // From HOLD: jump-register to addr, then fetch word w and land back in HOLD.
  task automatic go_hold(input logic [31:0] addr, input logic [31:0] w);
    step(0, '0, 1, 0, 0, 1, addr, 0);
    step(1, w, 0, 0, 0, 0, '0, 0);
  endtask

  initial begin
    @(negedge CLK);
    do_reset();
    // Back-to-back sequential fetch, 2 cycles per instruction.
    step(0, '0, 0, 0, 0, 0, '0, 0);
    for (int i = 0; i < 8; i++) step(1, $urandom, 1, 0, 0, 0, '0, 0);
    chk("seq_addr", imemaddr, 32'h10);

    // Wait states at 0x40.
    step(1, $urandom, 0, 0, 0, 0, '0, 0);
    step(0, '0, 1, 0, 0, 1, 32'h40, 0);
    for (int i = 0; i < 3; i++) step(0, '0, 0, 0, 0, 0, '0, 0);
    chk("wait_addr", imemaddr, 32'h40);
    step(1, 32'hCAFE_F00D, 0, 0, 0, 0, '0, 0);
    chk("wait_instr", instr, 32'hCAFE_F00D);
`ifdef FETCH_PERF_EN
    chk("wait_cnt3", wait_cnt, 32'd3);
`endif

    // BEQ with offset -1 word branches back onto itself.
    go_hold(32'h100, 32'h1000_FFFF);
    step(0, '0, 1, 1, 0, 0, '0, 0);
    chk("beq_tgt", imemaddr, 32'h100);
    step(1, 32'h0800_0010, 0, 0, 0, 0, '0, 0);

    // JR beats J, low address bits cleared.
    go_hold(32'h2000_0000, 32'h0800_0010);
    step(0, '0, 1, 0, 1, 1, 32'h333, 0);
    chk("jr_prio", imemaddr, 32'h330);
    step(1, 32'h0800_0010, 0, 0, 0, 0, '0, 0);
    step(0, '0, 1, 0, 1, 0, '0, 0);
    chk("j_tgt", imemaddr, 32'h40);
    step(1, $urandom, 0, 0, 0, 0, '0, 0);

    // PC wrap.
    go_hold(32'hFFFF_FFFC, 32'h0);
    step(0, '0, 1, 0, 0, 0, '0, 0);
    chk("pc_wrap", imemaddr, 32'h0);
    step(1, $urandom, 0, 0, 0, 0, '0, 0);

    // Halt is sticky.
    step(0, '0, 1, 0, 0, 0, '0, 1);
    for (int i = 0; i < 4; i++) step(1, $urandom, 1, 0, 0, 0, '0, 0);
    chk("halt_sticky", 32'(halted), 32'd1);

    // Reset mid-HOLD.
    do_reset();
    step(0, '0, 0, 0, 0, 0, '0, 0);
    step(1, 32'h1234_5678, 0, 0, 0, 0, '0, 0);
    step(0, '0, 0, 0, 0, 0, '0, 0);
    do_reset();
    chk("rst_hold_valid", 32'(instr_valid), 32'd0);
    chk("rst_hold_pc", imemaddr, 32'h0);

    // Random traffic with occasional halts and resets.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 79) == 0) do_reset();
      else step($urandom_range(0, 1) == 1, $urandom, $urandom_range(0, 1) == 1,
                $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                $urandom_range(0, 3) == 0, $urandom, $urandom_range(0, 15) == 0);
    end
    check_outputs();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
